// File: rtl/ysyx_22050058_pc_gen_pkg.sv
// Shared constants and types for the IF-stage fetch-PC generator.
//   ADDR_W_DEF  : default PC / address width
//   RST_VEC_DEF : default reset vector (truncated to ADDR_W at use)
//   STALL_BIT   : bit of the stall vector that freezes PC advance
//   INSN_STEP   : byte step between sequential fetches
//   pc_state_e  : IDLE/RUN encoding of the fetch FSM
package ysyx_22050058_pc_gen_pkg;

  localparam int unsigned ADDR_W_DEF  = 64;
  localparam logic [63:0] RST_VEC_DEF = 64'h0000_0000_8000_0000;
  localparam int unsigned STALL_BIT   = 0;
  localparam int unsigned INSN_STEP   = 4;

  // IDLE is the one dead cycle after reset; RUN issues fetches.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pc_state_e;

endpackage

// File: rtl/ysyx_22050058_pc_gen_if.sv
// Fetch request/response channel between the PC generator and instruction memory.
//   req_valid/req_ready : request handshake, fire = valid & ready
//   req_addr/req_epoch  : fetch address and the epoch it was issued under
//   rsp_valid/rsp_epoch : returning response and the epoch it carries
//   rsp_drop            : generator tells IF stage the response is stale
// master = PC generator side, slave = memory / IF side.
interface ysyx_22050058_pc_gen_if
  import ysyx_22050058_pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned EPOCH_W = 2
);

  logic               req_valid;
  logic               req_ready;
  logic [ADDR_W-1:0]  req_addr;
  logic [EPOCH_W-1:0] req_epoch;
  logic               rsp_valid;
  logic [EPOCH_W-1:0] rsp_epoch;
  logic               rsp_drop;

  modport master (
    output req_valid, req_addr, req_epoch, rsp_drop,
    input  req_ready, rsp_valid, rsp_epoch
  );

  modport slave (
    input  req_valid, req_addr, req_epoch, rsp_drop,
    output req_ready, rsp_valid, rsp_epoch
  );

endinterface

// File: rtl/ysyx_22050058_redir_arb.sv
// Fixed-priority redirect arbiter: lowest-index valid channel wins.
//   valid     : per-channel redirect request
//   addr_flat : packed targets, channel i at [i*ADDR_W +: ADDR_W]
//   sel_valid : any channel requesting
//   sel_addr  : target of the winning channel (0 when none)
//   sel_grant : one-hot grant of the winning channel
module ysyx_22050058_redir_arb
  import ysyx_22050058_pc_gen_pkg::*;
#(
  parameter int unsigned NUM    = 3,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [NUM-1:0]        valid,
  input  logic [NUM*ADDR_W-1:0] addr_flat,
  output logic                  sel_valid,
  output logic [ADDR_W-1:0]     sel_addr,
  output logic [NUM-1:0]        sel_grant
);

  assign sel_valid = |valid;

  // Walk from the lowest priority upward so the highest-priority hit is the last write.
  always_comb begin
    sel_addr  = '0;
    sel_grant = '0;
    for (int i = int'(NUM) - 1; i >= 0; i--) begin
      if (valid[i]) begin
        sel_grant    = '0;
        sel_grant[i] = 1'b1;
        sel_addr     = addr_flat[i*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/ysyx_22050058_pc_gen.sv
// IF-stage fetch-PC generator.
//   clk, rst     : clock, synchronous active-high reset
//   redir_valid  : per-channel redirect (index 0 = highest priority)
//   redir_addr   : packed redirect targets
//   stall        : stall vector, bit 0 freezes PC advance
//   bus          : fetch request/response channel (master side)
//   pc           : current fetch PC (also driven on bus.req_addr)
//   outst_cnt    : fetch requests in flight
//   misalign     : one-cycle pulse when an accepted redirect target is not word aligned
// bus.req_valid and bus.rsp_drop are combinational; everything else is registered.
module ysyx_22050058_pc_gen
  import ysyx_22050058_pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter logic [63:0] RST_VEC   = RST_VEC_DEF,
  parameter int unsigned NUM_REDIR = 3,
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned EPOCH_W   = 2,
  parameter int unsigned STALL_W   = 6,
  localparam int unsigned CNT_W    = $clog2(MAX_OUTST + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REDIR-1:0]        redir_valid,
  input  logic [NUM_REDIR*ADDR_W-1:0] redir_addr,
  input  logic [STALL_W-1:0]          stall,
  ysyx_22050058_pc_gen_if.master      bus,
  output logic [ADDR_W-1:0]           pc,
  output logic [CNT_W-1:0]            outst_cnt,
  output logic                        misalign
);

  pc_state_e          state;
  logic [EPOCH_W-1:0] epoch;
  logic               sel_valid;
  logic [ADDR_W-1:0]  sel_addr;
  logic [NUM_REDIR-1:0] sel_grant;
  logic               fire;

  // Redirect channel selection.
  ysyx_22050058_redir_arb #(
    .NUM    (NUM_REDIR),
    .ADDR_W (ADDR_W)
  ) u_redir_arb (
    .valid     (redir_valid),
    .addr_flat (redir_addr),
    .sel_valid (sel_valid),
    .sel_addr  (sel_addr),
    .sel_grant (sel_grant)
  );

  // The grant is only consumed as a sanity check on the arbiter.
  always_comb begin
    assert (!sel_valid || $onehot(sel_grant));
  end

  // Any pending redirect (even in IDLE) blocks the request so a stale address never goes out.
  assign bus.req_valid = (state == RUN) & ~stall[STALL_BIT] & ~sel_valid
                       & (outst_cnt < CNT_W'(MAX_OUTST));
  assign bus.req_addr  = pc;
  assign bus.req_epoch = epoch;
  assign fire          = bus.req_valid & bus.req_ready;

  // Stale when issued under an older epoch; a redirect this cycle has not bumped epoch yet.
  assign bus.rsp_drop  = bus.rsp_valid & (bus.rsp_epoch != epoch);

  // FSM, PC, epoch and misalign pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= ADDR_W'(RST_VEC);
      epoch    <= '0;
      misalign <= 1'b0;
    end else begin
      misalign <= 1'b0;
      if (state == IDLE) begin
        state <= RUN;
      end else if (sel_valid) begin
        // Redirect wins over stall and over a sequential fetch.
        pc       <= {sel_addr[ADDR_W-1:2], 2'b00};
        epoch    <= epoch + EPOCH_W'(1);
        misalign <= |sel_addr[1:0];
      end else if (fire) begin
        pc <= pc + ADDR_W'(INSN_STEP);
      end
    end
  end

  // In-flight counter; a response with nothing outstanding is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      outst_cnt <= '0;
    end else if (fire && !bus.rsp_valid) begin
      outst_cnt <= outst_cnt + CNT_W'(1);
    end else if (!fire && bus.rsp_valid && (outst_cnt != '0)) begin
      outst_cnt <= outst_cnt - CNT_W'(1);
    end
  end

endmodule

// File: doc/ysyx_22050058_pc_gen.md
Name: ysyx_22050058_pc_gen

Overview:
Parametrised fetch-PC generator for the IF stage. Holds the fetch PC, issues fetch requests over a valid/ready handshake, and limits in-flight requests to MAX_OUTST. Takes N prioritised redirect channels (trap, mispredict, jump) and tags each request with an epoch. Responses from a stale epoch are flagged so the IF stage drops them.

Parameters:
ADDR_W, 64, PC/address width in bits
RST_VEC, 64'h8000_0000, PC value loaded at reset (truncated to ADDR_W)
NUM_REDIR, 3, number of redirect channels; index 0 has highest priority
MAX_OUTST, 2, maximum fetch requests in flight (>=1)
EPOCH_W, 2, width of the epoch tag
STALL_W, 6, width of the pipeline stall vector; only bit 0 is used here

Ports:
clk  in  1  clock
rst  in  1  reset
redir_valid  in  NUM_REDIR  per-channel redirect request
redir_addr  in  NUM_REDIR*ADDR_W  packed targets; channel i at bits [i*ADDR_W +: ADDR_W]
stall  in  STALL_W  stall vector; bit 0 freezes PC advance
req_valid  out  1  fetch request valid
req_ready  in  1  memory accepts the request
req_addr  out  ADDR_W  fetch address (equals pc)
req_epoch  out  EPOCH_W  epoch tag for the request
rsp_valid  in  1  fetch response returned
rsp_epoch  in  EPOCH_W  epoch tag carried by the response
rsp_drop  out  1  response is stale and must be discarded
pc  out  ADDR_W  current fetch PC
outst_cnt  out  $clog2(MAX_OUTST+1)  requests in flight
misalign  out  1  one-cycle pulse: accepted redirect target had addr[1:0] != 0

Behaviour:
- Reset: rst, synchronous, active-high; clock clk.
- Values during reset: pc=RST_VEC, epoch=0, outst_cnt=0, misalign=0, FSM=IDLE. req_valid=0 because FSM != RUN.
- FSM IDLE -> RUN on the first clock edge with rst=0. This gives one dead cycle after reset, like a chip-enable delay. RUN -> IDLE only on rst.
- Redirect select: the lowest index i with redir_valid[i]=1 wins. Other channels are ignored that cycle.
- Redirect in RUN, at the clock edge:
  - pc <= {sel_addr[ADDR_W-1:2], 2'b00}
  - epoch <= epoch+1, wrapping modulo 2^EPOCH_W
  - misalign <= (sel_addr[1:0] != 0)
- Redirects in IDLE are ignored.
- Redirect overrides stall. A redirect with stall[0]=1 still updates pc and epoch.
- req_valid (combinational) = (FSM==RUN) & ~stall[0] & ~|redir_valid & (outst_cnt < MAX_OUTST).
- req_addr = pc; req_epoch = epoch.
- Fire = req_valid & req_ready. On fire, pc <= pc+4 at the edge, wrapping modulo 2^ADDR_W.
- With no fire and no redirect, pc holds.
- outst_cnt:
  - +1 on fire only; -1 on rsp_valid only; unchanged when both happen.
  - rsp_valid with outst_cnt==0 leaves it at 0 (saturating, no underflow).
- Responses count down outst_cnt regardless of epoch, stale or not.
- rsp_drop (combinational) = rsp_valid & (rsp_epoch != epoch).
  - Compare against the current epoch, so a response returning in the same cycle as a redirect is not yet stale.
- misalign is 0 in every cycle without an accepted redirect.
- Reset mid-operation: all state returns to reset values and in-flight requests are forgotten. The environment must not return responses for pre-reset requests.
- Epoch aliasing: more than 2^EPOCH_W-1 redirects while a request is in flight aliases the epoch. The system must size EPOCH_W so this cannot occur.

Decomposition:
- Shared define/package: ADDR_W default, RST_VEC, the IDLE/RUN state encodings, the stall-bit index (0), the instruction byte step (4).
- One natural sub-module: ysyx_22050058_redir_arb. It is a parametrised fixed-priority arbiter that returns the select valid, the chosen address and the one-hot grant for NUM_REDIR channels.
- Epoch, counter and FSM live in the top module.

Test Plan:
- Reset: hold rst 3 cycles, then release with req_ready=1 -> pc=0x8000_0000, req_valid=0 in the first cycle after release. From the next cycle, addresses 0x80000000, 0x80000004 and 0x80000008 are issued on consecutive cycles.
- Outstanding limit: MAX_OUTST=2, req_ready=1, no responses -> two fires (0x80000000, 0x80000004), then req_valid=0 with pc=0x80000008 and outst_cnt=2. A single rsp_valid drops outst_cnt to 1, and req_valid=1 the next cycle.
- Priority and misalignment: in one cycle, redir_valid=3'b110 with ch1=0x1000 and ch2=0x2000, stall[0]=1 -> pc=0x1000, epoch 0->1, misalign=0. Then redirect ch0=0x3002 -> pc=0x3000, misalign=1 for exactly one cycle.
- Stale drop: fire at epoch 0, redirect (epoch->1), then rsp_valid with rsp_epoch=0 -> rsp_drop=1 and outst_cnt decremented. A response with rsp_epoch=1 -> rsp_drop=0.
- Simultaneous fire and response: outst_cnt=1, fire and rsp_valid in the same cycle -> outst_cnt stays 1 and pc+=4. rsp_valid with outst_cnt=0 -> stays 0.
- Wrap: ADDR_W=32 with pc redirected to 0xFFFF_FFFC, then one fire -> pc=0x0000_0000. Four redirects with EPOCH_W=2 -> epoch returns to 0.
